ma_stage: RTL

//  Memory-access pipeline stage; consumes the *_ma bundle registered by the execute stage.

---
 rtl/ma_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ma_stage.sv
`timescale 1ns/1ps
// Memory-access stage: load/store alignment, data-memory req/ack handshake with
// pipe stall, and two write-back register levels (register file and EX forwarding).
module ma_stage #(
  parameter int DADR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_ld_ma,
  input  logic              cmd_st_ma,
  input  logic [4:0]        rd_adr_ma,
  input  logic [31:0]       rd_data_ma,
  input  logic              wbk_rd_reg_ma,
  input  logic [31:0]       st_data_ma,
  input  logic [2:0]        ldst_code_ma,
  input  logic              stall,
  input  logic              rst_pipe,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DADR_W-1:0] mem_adr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              dc_stall,
  output logic              dc_stall_fin,
  output logic              misalign_ma,
  output logic [4:0]        rd_adr_wb,
  output logic              wbk_rd_reg_wb,
  output logic [31:0]       wbk_data_wb,
  output logic [4:0]        rd_adr_wb2,
  output logic              wbk_rd_reg_wb2,
  output logic [31:0]       wbk_data_wb2
);

  typedef enum logic [1:0] {IDLE, BUSY, FIN} state_t;

  state_t      state, state_nxt;
  logic [1:0]  a, size;
  logic        acc, mis, issue, adv, ack_busy, kill, killed, done;
  logic [31:0] ld_buf;

  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] ofs);
    case (sz)
      2'b00:   store_be = 4'b0001 << ofs;
      2'b01:   store_be = 4'b0011 << ofs;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [2:0] code, input logic [1:0] ofs,
                                             input logic [31:0] word);
    logic [31:0] w;
    w = word >> {ofs, 3'b000};
    case (code)
      3'b000:  load_align = {{24{w[7]}}, w[7:0]};
      3'b100:  load_align = {24'h0, w[7:0]};
      3'b001:  load_align = {{16{w[15]}}, w[15:0]};
      3'b101:  load_align = {16'h0, w[15:0]};
      default: load_align = word;
    endcase
  endfunction

  assign a        = rd_data_ma[1:0];
  assign size     = ldst_code_ma[1:0];
  assign acc      = cmd_ld_ma | cmd_st_ma;
  assign mis      = ((size == 2'b01) & a[0]) | (size[1] & (a != 2'b00));
  // done keeps an externally stalled, already-completed access from issuing again
  assign issue    = (state == IDLE) & acc & ~mis & ~done & ~stall & ~rst_pipe;
  assign dc_stall = (state == BUSY) | ((state == IDLE) & acc & ~mis & ~done);
  assign dc_stall_fin = (state == FIN);
  assign adv      = ~stall & ~dc_stall & ~rst_pipe;
  assign ack_busy = (state == BUSY) & mem_ack;
  assign kill     = killed | rst_pipe;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = BUSY;
      BUSY:    if (mem_ack) state_nxt = kill ? IDLE : FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus cycle: request registered at issue, held stable until ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      killed    <= 1'b0;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      ld_buf    <= 32'h0;
    end else begin
      state  <= state_nxt;
      killed <= (state == BUSY) & ~mem_ack & kill;
      if (issue) begin
        mem_req   <= 1'b1;
        mem_we    <= cmd_st_ma;
        mem_adr   <= rd_data_ma[DADR_W+1:2];
        mem_be    <= cmd_st_ma ? store_be(size, a) : 4'hF;
        mem_wdata <= store_data(size, st_data_ma);
      end else if (ack_busy) begin
        mem_req <= 1'b0;
      end
      if (ack_busy & ~kill) ld_buf <= mem_rdata;
      if (rst_pipe)                done <= 1'b0;
      else if (ack_busy & ~killed) done <= 1'b1;
      else if (adv)                done <= 1'b0;
    end
  end

  // MA -> WB -> WB2 boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_ma    <= 1'b0;
      rd_adr_wb      <= 5'h0;
      wbk_rd_reg_wb  <= 1'b0;
      wbk_data_wb    <= 32'h0;
      rd_adr_wb2     <= 5'h0;
      wbk_rd_reg_wb2 <= 1'b0;
      wbk_data_wb2   <= 32'h0;
    end else if (rst_pipe) begin
      misalign_ma    <= 1'b0;
      rd_adr_wb      <= 5'h0;
      wbk_rd_reg_wb  <= 1'b0;
      wbk_data_wb    <= 32'h0;
      rd_adr_wb2     <= 5'h0;
      wbk_rd_reg_wb2 <= 1'b0;
      wbk_data_wb2   <= 32'h0;
    end else begin
      misalign_ma <= adv & acc & mis;
      if (adv) begin
        rd_adr_wb2     <= rd_adr_wb;
        wbk_rd_reg_wb2 <= wbk_rd_reg_wb;
        wbk_data_wb2   <= wbk_data_wb;
        rd_adr_wb      <= rd_adr_ma;
        wbk_rd_reg_wb  <= wbk_rd_reg_ma & ~cmd_st_ma & ~(acc & mis);
        wbk_data_wb    <= cmd_ld_ma ? load_align(ldst_code_ma, a, ld_buf) : rd_data_ma;
      end
    end
  end

endmodule
